st4_mem: RTL and testbench
==========================

Name: st4_mem

Overview:
- Memory-access stage of the multi-cycle CPU; consumes the 106-bit EXE->MEM bus and performs byte/word loads and stores on a synchronous data RAM with 1-cycle read latency.
- Produces a registered 70-bit MEM->WB bus and a one-cycle MEM_over completion pulse for the top-level stage sequencer.
- Non-memory instructions pass alu_result through unchanged.

Parameters:
- RD_LAT, 1, data RAM read latency in cycles; only 1 is supported.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- MEM_valid  input  1  level; high while MEM stage holds a valid instruction; EXE_MEM_bus_r is stable while high
- EXE_MEM_bus_r  input  106  {mem_control[3:0], store_data[31:0], alu_result[31:0], rf_wen, rf_wdest[4:0], pc[31:0]}
- dm_addr  output  32  data RAM byte address
- dm_wen  output  4  data RAM byte write enables
- dm_wdata  output  32  data RAM write data
- dm_rdata  input  32  data RAM read data, valid the cycle after address is sampled
- MEM_over  output  1  one-cycle pulse, stage complete
- MEM_WB_bus  output  70  {rf_wen, rf_wdest[4:0], mem_result[31:0], pc[31:0]}, registered
- MEM_pc  output  32  latched pc, for display

Behaviour:
- Reset is asynchronous and active-high. During reset: state=IDLE, MEM_over=0, MEM_WB_bus=0, MEM_pc=0, dm_wen=0.
- mem_control decode: bit3=load, bit2=store, bit1=word (1=word, 0=byte), bit0=sign-extend (byte loads only). If load and store are both set, the op is treated as load and no write occurs.
- dm_addr = {alu_result[31:2], 2'b00} for word accesses, alu_result for byte accesses. It is combinational from the bus.
- Word accesses ignore addr[1:0]; there is no misalignment trap.
- dm_wen is combinational and asserted only in IDLE with MEM_valid=1 and store=1. Word store: 4'b1111. Byte store: 4'b0001<<addr[1:0]. In all other states and cases it is 0, so each store writes exactly once.
- dm_wdata: word store = store_data; byte store = {4{store_data[7:0]}}.
- States:
  - IDLE: waiting. On MEM_valid=1, latch rf_wen, rf_wdest, pc, alu_result and mem_control/addr[1:0]. Load -> RD. Store or no mem op -> DONE, with mem_result=alu_result.
  - RD: dm_rdata is valid. Latch the formatted load value into mem_result. Go to DONE. If MEM_valid=0 in RD, abort to IDLE with no MEM_over.
  - DONE: MEM_over=1 for exactly this cycle. If MEM_valid=1, go to HOLD; otherwise go to IDLE.
  - HOLD: MEM_over=0. Outputs stay stable. Go to IDLE when MEM_valid=0. This prevents re-issuing the same instruction.
- Latency from MEM_valid rising to MEM_over: load 2 cycles; store or non-mem 1 cycle.
- Load formatting: byte = dm_rdata[8*addr[1:0]+:8], sign-extended when bit0=1, zero-extended otherwise. Word = dm_rdata.
- MEM_WB_bus and MEM_pc change only on latch edges and hold through DONE and HOLD. rf_wen is passed through as latched (store and non-writeback ops carry rf_wen=0 from decode).
- Reset asserted in any state returns to IDLE immediately. A store whose write edge has already occurred is not undone.

Test Plan:
- Reset mid-RD: assert reset while in RD -> MEM_over=0, MEM_WB_bus=0, state IDLE; after release with MEM_valid=0, nothing happens.
- Non-mem: mem_control=0, alu_result=0x0000_1234, rf_wen=1, rf_wdest=5, pc=0xBFC0_0010 -> MEM_over pulses 1 cycle after MEM_valid. MEM_WB_bus={1,5,0x1234,0xBFC0_0010}. dm_wen stays 0 throughout.
- Word store: mem_control=4'b0110, alu_result=0x100, store_data=0xDEAD_BEEF -> dm_wen=4'b1111 with dm_addr=0x100 for exactly one cycle. MEM_over follows 1 cycle later. Holding MEM_valid high for 5 more cycles causes no second write and no second MEM_over.
- Byte store: mem_control=4'b0100, alu_result=0x103, store_data=0x0000_00A5 -> dm_wen=4'b1000, dm_wdata=0xA5A5_A5A5.
- Byte loads, RAM word at 0x100 = 0x80FF_7F01:
  - lb at 0x103 (4'b1001) -> mem_result=0xFFFF_FF80.
  - lbu at 0x103 (4'b1000) -> 0x0000_0080.
  - lb at 0x101 -> 0x0000_007F.
  - In all three cases MEM_over occurs 2 cycles after MEM_valid.
- Word load / abort: lw at 0x102 (4'b1010) -> dm_addr=0x100, mem_result=0x80FF_7F01. Repeat with MEM_valid dropped during RD -> no MEM_over, and MEM_WB_bus retains the previous value.

Source files
------------

// File: rtl/st4_mem_if.sv
// Bundle between the MEM stage and its surroundings: the EXE->MEM bus, the data
// RAM port and the MEM->WB results. The slave side is the st4_mem stage itself.
interface st4_mem_if;
  logic         MEM_valid;
  logic [105:0] EXE_MEM_bus_r;
  logic [31:0]  dm_addr;
  logic [3:0]   dm_wen;
  logic [31:0]  dm_wdata;
  logic [31:0]  dm_rdata;
  logic         MEM_over;
  logic [69:0]  MEM_WB_bus;
  logic [31:0]  MEM_pc;

  modport master (
    output MEM_valid, EXE_MEM_bus_r, dm_rdata,
    input  dm_addr, dm_wen, dm_wdata, MEM_over, MEM_WB_bus, MEM_pc
  );

  modport slave (
    input  MEM_valid, EXE_MEM_bus_r, dm_rdata,
    output dm_addr, dm_wen, dm_wdata, MEM_over, MEM_WB_bus, MEM_pc
  );
endinterface

// File: rtl/st4_mem.sv
// Memory-access stage: byte/word loads and stores against a synchronous data RAM,
// producing a registered MEM->WB bus and a one-cycle completion pulse.
module st4_mem #(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     reset,
  st4_mem_if.slave mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  // Only a single-cycle RAM is supported, so read data is always ready in RD.
  localparam logic RD_READY = (RD_LAT == 1);

  function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic word,
                                           input logic sext, input logic [1:0] lo);
    logic signed [7:0] b;
    b = rdata[8*lo +: 8];
    if (word)      return rdata;
    else if (sext) return {{24{b[7]}}, b};
    else           return {24'd0, b};
  endfunction

  logic [1:0] state, state_nxt;

  // Stage p0: field decode straight off the incoming bus
  logic [3:0]  ctrl_p0;
  logic [31:0] sdata_p0, alu_p0, pc_p0;
  logic        rfw_p0;
  logic [4:0]  wd_p0;
  logic        is_load_p0, is_store_p0, is_word_p0, accept_p0;

  assign {ctrl_p0, sdata_p0, alu_p0, rfw_p0, wd_p0, pc_p0} = mem.EXE_MEM_bus_r;
  assign is_load_p0  = ctrl_p0[3];
  assign is_store_p0 = ctrl_p0[2] & ~ctrl_p0[3];
  assign is_word_p0  = ctrl_p0[1];
  assign accept_p0   = (state == S_IDLE) & mem.MEM_valid;

  assign mem.dm_addr  = is_word_p0 ? {alu_p0[31:2], 2'b00} : alu_p0;
  assign mem.dm_wdata = is_word_p0 ? sdata_p0 : {4{sdata_p0[7:0]}};
  // Writing only on the accept cycle guarantees one write per store.
  assign mem.dm_wen   = (accept_p0 & is_store_p0 & ~reset) ?
                        (is_word_p0 ? 4'b1111 : (4'b0001 << alu_p0[1:0])) : 4'b0000;

  // Stage p1: instruction context held while the load data returns
  logic        rfw_p1, word_p1, sext_p1;
  logic [4:0]  wd_p1;
  logic [31:0] pc_p1;
  logic [1:0]  lo_p1;

  always_ff @(posedge clk) begin
    if (accept_p0) begin
      rfw_p1  <= rfw_p0;
      wd_p1   <= wd_p0;
      pc_p1   <= pc_p0;
      word_p1 <= is_word_p0;
      sext_p1 <= ctrl_p0[0];
      lo_p1   <= alu_p0[1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (mem.MEM_valid) state_nxt = is_load_p0 ? S_RD : S_DONE;
      S_RD: begin
        if (!mem.MEM_valid) state_nxt = S_IDLE;
        else if (RD_READY)  state_nxt = S_DONE;
      end
      S_DONE: state_nxt = mem.MEM_valid ? S_HOLD : S_IDLE;
      S_HOLD: if (!mem.MEM_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Stage p2: MEM->WB result, written only when an instruction completes so an
  // aborted load leaves the previous result in place
  logic [69:0] wb_p2;
  logic [31:0] pc_disp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_p2   <= 70'd0;
      pc_disp <= 32'd0;
    end else begin
      if (accept_p0)
        pc_disp <= pc_p0;
      if (accept_p0 && !is_load_p0)
        wb_p2 <= {rfw_p0, wd_p0, alu_p0, pc_p0};
      else if (state == S_RD && mem.MEM_valid && RD_READY)
        wb_p2 <= {rfw_p1, wd_p1, fmt_load(mem.dm_rdata, word_p1, sext_p1, lo_p1), pc_p1};
    end
  end

  assign mem.MEM_WB_bus = wb_p2;
  assign mem.MEM_pc     = pc_disp;
  assign mem.MEM_over   = (state == S_DONE);

endmodule

// File: tb/tb_st4_mem.sv
// Bench for st4_mem: directed vector table, abort/reset sequences, and randomized
// traffic checked against a spec-level reference model with a shadow memory.
module tb_st4_mem;

  logic clk;
  logic reset;
  st4_mem_if bus ();

  st4_mem #(.RD_LAT(1)) dut (.clk(clk), .reset(reset), .mem(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.dm_wen[b]) ram[bus.dm_addr[11:2]][8*b +: 8] <= bus.dm_wdata[8*b +: 8];
    bus.dm_rdata <= ram[bus.dm_addr[11:2]];
  end

  int n_chk;
  int n_fail;
  logic [31:0] ref_mem [0:1023];
  logic [69:0] last_wb;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] sd;
    logic [31:0] alu;
    logic        rfw;
    logic [4:0]  wd;
    logic [31:0] pc;
    int          hold;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [31:0] res;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [3:0] ctrl, input logic [31:0] sd,
                                input logic [31:0] alu, output logic [3:0] wen,
                                output logic [31:0] wdata, output logic [31:0] addr,
                                output logic [31:0] res, output int lat);
    int off;
    int byt;
    logic [31:0] w;
    bit ld, st, wd;
    ld  = ctrl[3];
    st  = ctrl[2] && !ld;
    wd  = ctrl[1];
    off = int'(alu % 4);
    addr  = wd ? alu - 32'(off) : alu;
    lat   = ld ? 2 : 1;
    wen   = st ? (wd ? 4'd15 : 4'(1 << off)) : 4'd0;
    wdata = wd ? sd : 32'(sd[7:0]) * 32'h0101_0101;
    res   = alu;
    if (ld) begin
      w = ref_mem[(alu / 4) % 1024];
      if (wd) res = w;
      else begin
        byt = int'((w >> (8 * off)) & 32'hFF);
        if (ctrl[0] && byt >= 128) byt = byt - 256;
        res = 32'(byt);
      end
    end
  endfunction

  task automatic ref_store(input logic [3:0] ctrl, input logic [31:0] sd, input logic [31:0] alu);
    int idx;
    int off;
    logic [31:0] mask;
    idx = int'((alu / 4) % 1024);
    off = int'(alu % 4);
    if (ctrl[2] && !ctrl[3]) begin
      if (ctrl[1]) ref_mem[idx] = sd;
      else begin
        mask = 32'hFF << (8 * off);
        ref_mem[idx] = (ref_mem[idx] & ~mask) | ((32'(sd[7:0]) << (8 * off)) & mask);
      end
    end
  endtask

  task automatic run_txn(input vec_t v);
    int overs, wens, first, n;
    logic [69:0] e_wb;
    n = v.lat + 1 + v.hold;
    @(posedge clk); #1;
    bus.MEM_valid     = 1'b1;
    bus.EXE_MEM_bus_r = {v.ctrl, v.sd, v.alu, v.rfw, v.wd, v.pc};
    overs = 0; wens = 0; first = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("dm_addr", 70'(bus.dm_addr), 70'(v.addr));
        chk("dm_wen", 70'(bus.dm_wen), 70'(v.wen));
        if (v.wen != 4'd0) chk("dm_wdata", 70'(bus.dm_wdata), 70'(v.wdata));
      end
      if (bus.dm_wen != 4'd0) wens++;
      if (bus.MEM_over) begin
        overs++;
        if (first < 0) first = k;
      end
      if (k < n - 1) @(posedge clk);
    end
    chk("latency", 70'(first), 70'(v.lat));
    @(posedge clk); #1;
    bus.MEM_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.dm_wen != 4'd0) wens++;
      if (bus.MEM_over) overs++;
    end
    e_wb = {v.rfw, v.wd, v.res, v.pc};
    chk("over_count", 70'(overs), 70'd1);
    chk("write_count", 70'(wens), 70'(v.wen != 4'd0));
    chk("MEM_WB_bus", bus.MEM_WB_bus, e_wb);
    chk("MEM_pc", 70'(bus.MEM_pc), 70'(v.pc));
    last_wb = e_wb;
    ref_store(v.ctrl, v.sd, v.alu);
  endtask

  task automatic run_random(input logic [3:0] ctrl, input logic [31:0] sd, input logic [31:0] alu,
                            input logic [31:0] pc, input int hold);
    vec_t v;
    v.ctrl = ctrl; v.sd = sd; v.alu = alu; v.pc = pc; v.hold = hold;
    v.rfw  = 1'($urandom); v.wd = 5'($urandom);
    model(ctrl, sd, alu, v.wen, v.wdata, v.addr, v.res, v.lat);
    run_txn(v);
  endtask

  vec_t tbl [11];

  initial begin
    int overs;
    n_chk = 0; n_fail = 0; last_wb = 70'd0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
    tbl[0]  = '{4'b0000, 32'h0,         32'h0000_1234, 1'b1, 5'd5, 32'hBFC0_0010, 0, 4'b0000, 32'h0,         32'h0000_1234, 32'h0000_1234, 1};
    tbl[1]  = '{4'b0110, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 5'd0, 32'hBFC0_0014, 5, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0100, 32'h0000_0100, 1};
    tbl[2]  = '{4'b0100, 32'h0000_00A5, 32'h0000_0103, 1'b0, 5'd0, 32'hBFC0_0018, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0000_0103, 32'h0000_0103, 1};
    tbl[3]  = '{4'b0110, 32'h80FF_7F01, 32'h0000_0100, 1'b0, 5'd0, 32'hBFC0_001C, 1, 4'b1111, 32'h80FF_7F01, 32'h0000_0100, 32'h0000_0100, 1};
    tbl[4]  = '{4'b1001, 32'h0,         32'h0000_0103, 1'b1, 5'd8, 32'hBFC0_0020, 0, 4'b0000, 32'h0,         32'h0000_0103, 32'hFFFF_FF80, 2};
    tbl[5]  = '{4'b1000, 32'h0,         32'h0000_0103, 1'b1, 5'd9, 32'hBFC0_0024, 2, 4'b0000, 32'h0,         32'h0000_0103, 32'h0000_0080, 2};
    tbl[6]  = '{4'b1001, 32'h0,         32'h0000_0101, 1'b1, 5'd10, 32'hBFC0_0028, 0, 4'b0000, 32'h0,        32'h0000_0101, 32'h0000_007F, 2};
    tbl[7]  = '{4'b1010, 32'h0,         32'h0000_0102, 1'b1, 5'd11, 32'hBFC0_002C, 0, 4'b0000, 32'h0,        32'h0000_0100, 32'h80FF_7F01, 2};
    tbl[8]  = '{4'b1110, 32'h1234_5678, 32'h0000_0100, 1'b1, 5'd12, 32'hBFC0_0030, 0, 4'b0000, 32'h0,        32'h0000_0100, 32'h80FF_7F01, 2};
    tbl[9]  = '{4'b1001, 32'h0,         32'h0000_0102, 1'b1, 5'd13, 32'hBFC0_0034, 0, 4'b0000, 32'h0,        32'h0000_0102, 32'hFFFF_FFFF, 2};
    tbl[10] = '{4'b1000, 32'h0,         32'h0000_0100, 1'b1, 5'd14, 32'hBFC0_0038, 0, 4'b0000, 32'h0,        32'h0000_0100, 32'h0000_0001, 2};

    reset = 1'b1;
    bus.MEM_valid = 1'b0;
    bus.EXE_MEM_bus_r = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_MEM_over", 70'(bus.MEM_over), 70'd0);
    chk("reset_MEM_WB_bus", bus.MEM_WB_bus, 70'd0);
    chk("reset_MEM_pc", 70'(bus.MEM_pc), 70'd0);
    chk("reset_dm_wen", 70'(bus.dm_wen), 70'd0);
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 11; i++) run_txn(tbl[i]);

    // Load aborted in RD: no completion, result bus keeps the previous value
    @(posedge clk); #1;
    bus.MEM_valid = 1'b1;
    bus.EXE_MEM_bus_r = {4'b1010, 32'h0, 32'h0000_0102, 1'b1, 5'd3, 32'hBFC0_0040};
    @(posedge clk); #1 bus.MEM_valid = 1'b0;
    overs = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.MEM_over) overs++;
    end
    chk("abort_over_count", 70'(overs), 70'd0);
    chk("abort_MEM_WB_bus", bus.MEM_WB_bus, last_wb);

    // Reset while a load sits in RD
    @(posedge clk); #1;
    bus.MEM_valid = 1'b1;
    bus.EXE_MEM_bus_r = {4'b1000, 32'h0, 32'h0000_0103, 1'b1, 5'd4, 32'hBFC0_0044};
    @(posedge clk); #1 reset = 1'b1;
    #1;
    chk("rst_rd_MEM_over", 70'(bus.MEM_over), 70'd0);
    chk("rst_rd_MEM_WB_bus", bus.MEM_WB_bus, 70'd0);
    chk("rst_rd_MEM_pc", 70'(bus.MEM_pc), 70'd0);
    chk("rst_rd_dm_wen", 70'(bus.dm_wen), 70'd0);
    @(posedge clk); #1;
    bus.MEM_valid = 1'b0;
    reset = 1'b0;
    overs = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.MEM_over || bus.dm_wen != 4'd0) overs++;
    end
    chk("rst_rd_quiet", 70'(overs), 70'd0);
    chk("rst_rd_WB_after", bus.MEM_WB_bus, 70'd0);
    last_wb = 70'd0;

    for (int i = 0; i < 16; i++)
      run_random({3'b011, 1'($urandom)}, $urandom, 32'h200 + 32'(4 * i),
                 32'hBFC1_0000 + 32'(4 * i), int'($urandom_range(0, 3)));

    for (int i = 0; i < 60; i++) begin
      logic [3:0] c;
      logic [31:0] a;
      c = 4'($urandom_range(0, 15));
      a = (c[3:2] == 2'b00) ? $urandom : 32'h200 + 32'($urandom_range(0, 63));
      run_random(c, $urandom, a, $urandom, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
